// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit in the EX stage.
// The FSM runs IDLE -> CALC -> FIX -> DONE. CALC retires one bit per edge:
// shift-add for multiplies, restoring division for divides.
// Divide-by-zero and signed overflow are resolved when the op starts.
// Optional feature macro: FAST_MUL_EN. When defined, multiplies use a
// single-cycle 33x33 signed multiplier and skip CALC/FIX.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            stop,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Operand decode for a new request: signedness, magnitudes, special cases.
  logic            is_div, sg1, sg2, s1, s2, div_zero, div_ovf, neg_start;
  logic [XLEN-1:0] mag1, mag2, spec_res;

  assign is_div    = funct3[2];
  assign sg1       = is_div ? ~funct3[0] : (funct3[0] ^ funct3[1]);
  assign sg2       = is_div ? ~funct3[0] : (funct3 == 3'd1);
  assign s1        = sg1 & rs1_data[XLEN-1];
  assign s2        = sg2 & rs2_data[XLEN-1];
  assign mag1      = s1 ? -rs1_data : rs1_data;
  assign mag2      = s2 ? -rs2_data : rs2_data;
  // Remainder follows the dividend; quotient and product follow sign xor.
  assign neg_start = (is_div & funct3[1]) ? s1 : (s1 ^ s2);
  assign div_zero  = is_div & (rs2_data == '0);
  assign div_ovf   = is_div & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == '1);
  assign spec_res  = div_zero ? (funct3[1] ? rs1_data : '1)
                              : (funct3[1] ? '0 : MIN_NEG);

`ifdef FAST_MUL_EN
  // Single-cycle signed multiply; unsigned operands zero-extend, signed ones sign-extend.
  logic [2*XLEN-1:0] fa, fb, fprod;
  logic [XLEN-1:0]   fast_res;
  assign fa       = {{XLEN{s1}}, rs1_data};
  assign fb       = {{XLEN{s2}}, rs2_data};
  assign fprod    = fa * fb;
  assign fast_res = (funct3[1:0] == 2'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif

  // One iteration: shift-add multiply or restoring-divide step.
  logic [XLEN:0]     add_sum, trial;
  logic [2*XLEN-1:0] step;
  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    step    = {add_sum, acc_q[XLEN-1:1]};
    if (f3_q[2]) begin
      step = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                         : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign fix-up and word select once the magnitude result is complete.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;
  always_comb begin
    prod_s  = neg_q ? -acc_q : acc_q;
    quo_s   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res = (f3_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    if (f3_q[2]) fix_res = f3_q[1] ? rem_s : quo_s;
  end

  // Next-state logic: stop holds all state, flush aborts, then normal flow.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = done_q;
    if (stop) begin
      state_d = state_q;
    end else if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_d  = 1'b0;
          state_d = S_IDLE;
          if (start) begin
            f3_d  = funct3;
            neg_d = neg_start;
            cnt_d = '0;
            acc_d = {{XLEN{1'b0}}, is_div ? mag1 : mag2};
            opb_d = is_div ? mag2 : mag1;
            if (div_zero || div_ovf) begin
              result_d = spec_res;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end
`ifdef FAST_MUL_EN
            else if (!is_div) begin
              result_d = fast_res;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end
`endif
            else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = fix_res;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for stop/flush/reset.
// Latencies are counted in rising edges after the start edge.
module tb_ex_muldiv_unit;

`ifdef FAST_MUL_EN
  localparam int ML = 0;
`else
  localparam int ML = 33;
`endif

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic        busy, done;
  logic [31:0] result;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stop(stop), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pl;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin pl = sa * sb; p = pl; return p[63:32]; end
      3'd2: begin pl = sa * longint'(ub); p = pl; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
    if (!f[2]) return ML;
    return 33;
  endfunction

  // Present a request for one cycle; returns at the falling edge after the start edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one op to completion; optional stop window and mid-op start injection.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                        input int stop_at, input int stop_len, input int inj_at);
    int cnt, bc;
    cnt = 0; bc = 0;
    issue(f, a, b);
    while (!done && cnt < 100) begin
      if (busy) bc++;
      if (cnt == stop_at) stop = 1'b1;
      if (cnt == stop_at + stop_len) stop = 1'b0;
      if (cnt == inj_at) begin start = 1'b1; funct3 = 3'd7; rs1_data = 32'd9; rs2_data = 32'd4; end
      if (cnt == inj_at + 1) start = 1'b0;
      @(negedge clk);
      cnt++;
    end
    stop = 1'b0; start = 1'b0;
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " latency"}, 32'(cnt), 32'(lat));
    chk({nm, " result"}, result, exp_res);
    chk({nm, " busy_cycles"}, 32'(bc), 32'(lat));
    @(negedge clk);
    chk({nm, " done_pulse"}, 32'(done), 32'd0);
    chk({nm, " result_hold"}, result, exp_res);
  endtask

  vec_t tbl[15];

  initial begin
    int pulses;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int sa, sl, el;

    tbl[0]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
    tbl[1]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
    tbl[2]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    tbl[3]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0};
    tbl[5]  = '{3'd7, 32'd5, 32'd0, 32'd5, 0};
    tbl[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    tbl[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0};
    tbl[8]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, ML};
    tbl[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, ML};
    tbl[10] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
    tbl[11] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
    tbl[12] = '{3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 0};
    tbl[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0};
    tbl[14] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML};

    // Reset state
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, -1, 0, -1);

    // Stop for 5 cycles starting at cycle 10
    run_op("divu_stop", 3'd5, 32'd100, 32'd7, 32'd14, 38, 10, 5, -1);

    // Start while busy is ignored
    run_op("start_ignored", 3'd5, 32'd100, 32'd7, 32'd14, 33, -1, 0, 5);

    // Flush mid-op: no done, result keeps its prior value (14)
    issue(3'd5, 32'd200, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    chk("flush no_done", 32'(pulses), 32'd0);
    chk("flush result", result, 32'd14);

    // Flush together with stop waits for stop to drop
    issue(3'd5, 32'd200, 32'd3);
    repeat (10) @(negedge clk);
    stop = 1'b1; flush = 1'b1;
    repeat (3) begin @(negedge clk); chk("flush_stop held busy", 32'(busy), 32'd1); end
    stop = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_stop busy", 32'(busy), 32'd0);
    chk("flush_stop done", 32'(done), 32'd0);
    chk("flush_stop result", result, 32'd14);

    // Start in the same cycle as flush is dropped (special-case op included)
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd0; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush busy", 32'(busy), 32'd0);
    chk("start_flush done", 32'(done), 32'd0);
    chk("start_flush result", result, 32'd14);

    // Asynchronous reset mid-CALC
    issue(3'd5, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'd5, 32'd100, 32'd7, 32'd14, 33, -1, 0, -1);

    // Randomized ops with random stop windows against the reference model
    for (int i = 0; i < 48; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: ra = 32'h0; 1: ra = 32'h8000_0000; 2: ra = 32'hFFFF_FFFF; 3: ra = 32'd1;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0; 1: rb = 32'h8000_0000; 2: rb = 32'hFFFF_FFFF; 3: rb = 32'd1;
        default: rb = $urandom;
      endcase
      sa = $urandom_range(0, 20);
      sl = $urandom_range(0, 4);
      el = exp_lat(rf, ra, rb);
      if (el != 0) el = el + sl;
      run_op($sformatf("rnd%0d f%0d %h %h", i, rf, ra, rb), rf, ra, rb, ref_res(rf, ra, rb), el,
             sa, sl, -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
